// File: rtl/memif_stream_reader.sv
// memif read master: fetches a contiguous word run in credit-limited bursts into a
// show-ahead FIFO and presents it as a valid/ready stream with a last flag.
module memif_stream_reader #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 16,
  parameter int unsigned FIFO_LOG = 7,
  parameter int unsigned BURST    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctl_start,
  input  logic          ctl_abort,
  input  logic [AW-1:0] ctl_addr,
  input  logic [15:0]   ctl_words,
  output logic          ctl_busy,
  output logic          ctl_done,
  output logic [AW-1:0] mi_addr,
  output logic [6:0]    mi_len,
  output logic          mi_rw,
  output logic          mi_valid,
  input  logic          mi_ready,
  output logic [DW-1:0] mi_wdata,
  input  logic          mi_wack,
  input  logic          mi_wlast,
  input  logic [DW-1:0] mi_rdata,
  input  logic          mi_rstb,
  input  logic          mi_rlast,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG;
  localparam int unsigned CW    = FIFO_LOG + 1;
  localparam int unsigned SW    = CW + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FLUSH} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr_q;
  logic [15:0]   words_q;
  logic [15:0]   rem_req;
  logic [15:0]   pop_cnt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [FIFO_LOG-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          abort_q;
  logic          done_q;
  logic          done_set;

  logic [CW-1:0] burst_n;
  logic          credit_ok;
  logic          hs;
  logic          accept_start;
  logic          strobe_in;
  logic          push;
  logic          pop;
  logic          unused_inputs;

  always_comb unused_inputs = ^{mi_wack, mi_wlast};

  always_comb begin
    if (rem_req < 16'(BURST)) burst_n = CW'(rem_req);
    else                      burst_n = CW'(BURST);
  end

  // Credit: FIFO free space must cover words already in flight plus the next burst.
  always_comb credit_ok = (SW'(count) + SW'(outstanding) + SW'(burst_n)) <= SW'(DEPTH);

  always_comb begin
    accept_start = (state == IDLE) && ctl_start && (ctl_words != '0);
    strobe_in    = (state == WAIT) && mi_rstb && (outstanding != '0);
    push         = strobe_in && !abort_q && (count != CW'(DEPTH));
    out_valid    = (count != '0) && (state != FLUSH);
    pop          = out_valid && out_ready;
    out_last     = out_valid && !abort_q && (pop_cnt == words_q - 16'd1);
    out_data     = mem[rd_ptr];
    hs           = mi_valid && mi_ready;
    mi_addr      = addr_q;
    mi_len       = mi_valid ? 7'(burst_n - CW'(1)) : '0;
    mi_rw        = 1'b1;
    mi_wdata     = '0;
    ctl_busy     = (state != IDLE);
    ctl_done     = done_q;
  end

  always_comb begin
    state_nx = state;
    mi_valid = 1'b0;
    done_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctl_start) begin
          if (ctl_words != '0) state_nx = ISSUE;
          else                 done_set = 1'b1;
        end
      end
      ISSUE: begin
        mi_valid = credit_ok;
        if (credit_ok && mi_ready) state_nx = WAIT;
        else if (ctl_abort)        state_nx = FLUSH;
      end
      WAIT: begin
        if (mi_rstb && mi_rlast) begin
          if (abort_q || ctl_abort) state_nx = FLUSH;
          else if (rem_req != '0)   state_nx = ISSUE;
          else                      state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (ctl_abort) begin
          state_nx = FLUSH;
        end else if (pop && out_last) begin
          state_nx = IDLE;
          done_set = 1'b1;
        end
      end
      FLUSH: begin
        state_nx = IDLE;
        done_set = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      words_q     <= '0;
      rem_req     <= '0;
      pop_cnt     <= '0;
      outstanding <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_set;
      if (accept_start) begin
        addr_q      <= ctl_addr;
        words_q     <= ctl_words;
        rem_req     <= ctl_words;
        pop_cnt     <= '0;
        outstanding <= '0;
        abort_q     <= 1'b0;
      end else begin
        if (hs) begin
          addr_q  <= addr_q + AW'(burst_n);
          rem_req <= rem_req - 16'(burst_n);
        end
        // An abort racing the handshake still owns a burst, so it waits for rlast.
        if (state == FLUSH)
          abort_q <= 1'b0;
        else if (ctl_abort && ((state == WAIT) || hs))
          abort_q <= 1'b1;
        if (state == FLUSH)
          outstanding <= '0;
        else
          outstanding <= outstanding + (hs ? burst_n : CW'(0)) - CW'(strobe_in);
        if (pop) pop_cnt <= pop_cnt + 16'd1;
      end
      if (state == FLUSH) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + FIFO_LOG'(1);
        if (pop)  rd_ptr <= rd_ptr + FIFO_LOG'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mi_rdata;
  end

endmodule

// File: tb/tb_memif_stream_reader.sv
// Bench for memif_stream_reader: PSRAM responder returning data = word address, stream
// sink logging pops, and a run-level model of expected requests, data and last flags.
module tb_memif_stream_reader;

  localparam int BURST = 64;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctl_start, ctl_abort;
  logic [31:0] ctl_addr;
  logic [15:0] ctl_words;
  logic        ctl_busy, ctl_done;
  logic [31:0] mi_addr;
  logic [6:0]  mi_len;
  logic        mi_rw, mi_valid, mi_ready;
  logic [15:0] mi_wdata;
  logic        mi_wack, mi_wlast;
  logic [15:0] mi_rdata;
  logic        mi_rstb, mi_rlast;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last;

  always #5 clk = ~clk;

  memif_stream_reader #(.AW(32), .DW(16), .FIFO_LOG(7), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .ctl_start(ctl_start), .ctl_abort(ctl_abort), .ctl_addr(ctl_addr), .ctl_words(ctl_words),
    .ctl_busy(ctl_busy), .ctl_done(ctl_done),
    .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid), .mi_ready(mi_ready),
    .mi_wdata(mi_wdata), .mi_wack(mi_wack), .mi_wlast(mi_wlast),
    .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  int checks = 0;
  int failures = 0;

  int ready_wait = 0;
  int gap_pct = 0;
  int burst_left = 0;
  int burst_sent = 0;
  logic [31:0] burst_addr;
  int strobes_total = 0;
  int pops_total = 0;
  int strobes_base = 0;
  int pops_base = 0;
  int max_occ = 0;
  int done_cnt = 0;
  int done_base = 0;
  int last_seen = 0;
  int strobes_at_done = 0;

  logic [31:0] req_addr_q[$];
  logic [6:0]  req_len_q[$];
  int          req_wait_q[$];
  bit          req_unstable_q[$];
  logic [15:0] got_q[$];
  bit          got_last_q[$];

  // PSRAM responder: decides mi_ready and strobes at negedge, effective at the next posedge.
  initial begin : memory
    int wait_cnt;
    bit unstable;
    logic [31:0] first_addr;
    logic [6:0]  first_len;
    wait_cnt = 0; unstable = 1'b0; first_addr = '0; first_len = '0;
    mi_ready = 1'b0; mi_rstb = 1'b0; mi_rlast = 1'b0; mi_rdata = '0;
    mi_wack = 1'b0; mi_wlast = 1'b0; burst_addr = '0;
    forever begin
      @(negedge clk);
      if (burst_left > 0 && int'($urandom_range(99)) >= gap_pct) begin
        mi_rstb  = 1'b1;
        mi_rdata = burst_addr[15:0];
        mi_rlast = (burst_left == 1);
        burst_addr = burst_addr + 32'd1;
        burst_left--;
        burst_sent++;
        strobes_total++;
      end else begin
        mi_rstb  = 1'b0;
        mi_rlast = 1'b0;
        mi_rdata = 16'($urandom);
      end
      mi_ready = 1'b0;
      if (mi_valid) begin
        if (wait_cnt == 0) begin
          first_addr = mi_addr;
          first_len  = mi_len;
        end else if (mi_addr !== first_addr || mi_len !== first_len) begin
          unstable = 1'b1;
        end
        if (wait_cnt >= ready_wait) begin
          mi_ready = 1'b1;
          req_addr_q.push_back(mi_addr);
          req_len_q.push_back(mi_len);
          req_wait_q.push_back(wait_cnt);
          req_unstable_q.push_back(unstable);
          burst_addr = mi_addr;
          burst_left = int'(mi_len) + 1;
          burst_sent = 0;
          wait_cnt = 0;
          unstable = 1'b0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        unstable = 1'b0;
      end
    end
  end

  initial begin : sink
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_last_q.push_back(out_last);
        pops_total++;
      end
      if (out_valid && out_last) last_seen++;
      if (ctl_done) begin
        done_cnt++;
        strobes_at_done = strobes_total;
      end
    end
  end

  initial begin : occupancy
    int occ;
    forever begin
      @(posedge clk);
      #2;
      occ = (strobes_total - strobes_base) - (pops_total - pops_base);
      if (occ > max_occ) max_occ = occ;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] base, input int words);
    tick();
    req_addr_q.delete(); req_len_q.delete(); req_wait_q.delete(); req_unstable_q.delete();
    got_q.delete(); got_last_q.delete();
    strobes_base = strobes_total;
    pops_base = pops_total;
    max_occ = 0;
    done_base = done_cnt;
    last_seen = 0;
    ctl_addr = base;
    ctl_words = 16'(words);
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
  endtask

  task automatic wait_done(input int ready_pct, input int budget, input string name);
    int cyc = 0;
    while (done_cnt == done_base && cyc < budget) begin
      out_ready = (int'($urandom_range(99)) < ready_pct);
      tick();
      cyc++;
    end
    checks++;
    if (done_cnt == done_base) begin
      failures++;
      $display("FAIL %s done_timeout got=no_done exp=done_within_%0d", name, budget);
    end
    repeat (3) tick();
    out_ready = 1'b0;
  endtask

  task automatic check_run(input logic [31:0] base, input int words, input string name);
    int nreq = (words + BURST - 1) / BURST;
    checks++;
    if (req_addr_q.size() !== nreq) begin
      failures++;
      $display("FAIL %s req_count got=%0d exp=%0d", name, req_addr_q.size(), nreq);
    end
    for (int i = 0; i < nreq && i < req_addr_q.size(); i++) begin
      logic [31:0] ea;
      int n;
      logic [6:0] el;
      ea = base + 32'(i * BURST);
      n = words - i * BURST;
      if (n > BURST) n = BURST;
      el = 7'(n - 1);
      checks++;
      if (req_addr_q[i] !== ea || req_len_q[i] !== el) begin
        failures++;
        $display("FAIL %s req%0d got=%h/%0d exp=%h/%0d", name, i, req_addr_q[i], req_len_q[i], ea, el);
      end
    end
    checks++;
    if (got_q.size() !== words) begin
      failures++;
      $display("FAIL %s word_count got=%0d exp=%0d", name, got_q.size(), words);
    end
    for (int i = 0; i < words && i < got_q.size(); i++) begin
      logic [31:0] a;
      a = base + 32'(i);
      checks++;
      if (got_q[i] !== a[15:0] || got_last_q[i] !== (i == words - 1)) begin
        failures++;
        $display("FAIL %s word%0d got=%h/last%0d exp=%h/last%0d", name, i, got_q[i], got_last_q[i],
                 a[15:0], (i == words - 1));
      end
    end
    checks++;
    if (done_cnt - done_base !== 1) begin
      failures++;
      $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt - done_base);
    end
    checks++;
    if (ctl_busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after got=busy%b/valid%b exp=busy0/valid0", name, ctl_busy, out_valid);
    end
    checks++;
    if (max_occ > DEPTH) begin
      failures++;
      $display("FAIL %s occupancy got=%0d exp<=%0d", name, max_occ, DEPTH);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({ctl_busy, ctl_done, mi_valid, out_valid, out_last} !== 5'b0 || mi_addr !== 32'd0 ||
        mi_len !== 7'd0 || mi_rw !== 1'b1 || mi_wdata !== 16'd0) begin
      failures++;
      $display("FAIL reset_values got=busy%b done%b mv%b ov%b ol%b addr%h len%0d rw%b wd%h exp=zeros_rw1",
               ctl_busy, ctl_done, mi_valid, out_valid, out_last, mi_addr, mi_len, mi_rw, mi_wdata);
    end
  endtask

  task automatic test_basic();
    gap_pct = 0;
    start_run(32'h1000, 200);
    wait_done(100, 2000, "basic");
    check_run(32'h1000, 200, "basic");
  endtask

  task automatic test_hold_ready();
    out_ready = 1'b0;
    start_run(32'h0000_2200, 10);
    repeat (60) tick();
    checks++;
    if (req_addr_q.size() !== 1 || strobes_total - strobes_base !== 10 || out_valid !== 1'b1 ||
        got_q.size() !== 0 || ctl_busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_buffered got=req%0d strobes%0d ov%b pops%0d busy%b exp=req1 strobes10 ov1 pops0 busy1",
               req_addr_q.size(), strobes_total - strobes_base, out_valid, got_q.size(), ctl_busy);
    end
    wait_done(100, 500, "hold");
    check_run(32'h0000_2200, 10, "hold");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    start_run(32'h0001_0000, 300);
    repeat (400) tick();
    checks++;
    if (req_addr_q.size() !== 2 || strobes_total - strobes_base !== 128 || mi_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_credit_stall got=req%0d buffered%0d mv%b exp=req2 buffered128 mv0",
               req_addr_q.size(), strobes_total - strobes_base, mi_valid);
    end
    wait_done(60, 5000, "backpressure");
    check_run(32'h0001_0000, 300, "backpressure");
    checks++;
    if (max_occ !== DEPTH) begin
      failures++;
      $display("FAIL bp_peak got=%0d exp=%0d", max_occ, DEPTH);
    end
  endtask

  task automatic test_abort();
    int cyc = 0;
    gap_pct = 0;
    out_ready = 1'b0;
    start_run(32'h0000_3000, 64);
    while ((req_addr_q.size() == 0 || burst_sent < 20) && cyc < 300) begin
      tick();
      cyc++;
    end
    ctl_abort = 1'b1;
    tick();
    ctl_abort = 1'b0;
    wait_done(0, 500, "abort_wait");
    repeat (10) tick();
    checks++;
    if (done_cnt - done_base !== 1 || out_valid !== 1'b0 || ctl_busy !== 1'b0 || last_seen !== 0) begin
      failures++;
      $display("FAIL abort_wait_end got=done%0d ov%b busy%b last%0d exp=done1 ov0 busy0 last0",
               done_cnt - done_base, out_valid, ctl_busy, last_seen);
    end
    checks++;
    if (strobes_at_done - strobes_base !== 64 || req_addr_q.size() !== 1) begin
      failures++;
      $display("FAIL abort_wait_rlast got=strobes%0d req%0d exp=strobes64 req1",
               strobes_at_done - strobes_base, req_addr_q.size());
    end
    start_run(32'h0000_3100, 70);
    wait_done(70, 2000, "after_abort");
    check_run(32'h0000_3100, 70, "after_abort");
    ready_wait = 1000;
    start_run(32'h0000_5000, 50);
    repeat (4) tick();
    checks++;
    if (mi_valid !== 1'b1 || mi_addr !== 32'h0000_5000 || mi_len !== 7'd49) begin
      failures++;
      $display("FAIL abort_issue_req got=mv%b %h/%0d exp=mv1 00005000/49", mi_valid, mi_addr, mi_len);
    end
    ctl_abort = 1'b1;
    tick();
    ctl_abort = 1'b0;
    wait_done(0, 20, "abort_issue");
    checks++;
    if (req_addr_q.size() !== 0 || mi_valid !== 1'b0 || ctl_busy !== 1'b0 || done_cnt - done_base !== 1) begin
      failures++;
      $display("FAIL abort_issue_end got=req%0d mv%b busy%b done%0d exp=req0 mv0 busy0 done1",
               req_addr_q.size(), mi_valid, ctl_busy, done_cnt - done_base);
    end
    ready_wait = 0;
  endtask

  task automatic test_stall();
    ready_wait = 5;
    start_run(32'h0000_4000, 40);
    wait_done(100, 1000, "stall");
    check_run(32'h0000_4000, 40, "stall");
    checks++;
    if (req_wait_q.size() !== 1 || (req_wait_q.size() > 0 && (req_wait_q[0] !== 5 || req_unstable_q[0] !== 1'b0))) begin
      failures++;
      $display("FAIL stall_hold got=reqs%0d wait%0d unstable%0d exp=reqs1 wait5 unstable0", req_wait_q.size(),
               (req_wait_q.size() > 0) ? req_wait_q[0] : -1, (req_unstable_q.size() > 0) ? int'(req_unstable_q[0]) : -1);
    end
    ready_wait = 0;
  endtask

  task automatic test_zero_and_busy();
    start_run(32'h0000_6000, 0);
    checks++;
    if (ctl_done !== 1'b1 || ctl_busy !== 1'b0 || mi_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got=done%b busy%b mv%b exp=done1 busy0 mv0", ctl_done, ctl_busy, mi_valid);
    end
    tick();
    checks++;
    if (ctl_done !== 1'b0 || ctl_busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse got=done%b busy%b exp=done0 busy0", ctl_done, ctl_busy);
    end
    repeat (10) tick();
    checks++;
    if (req_addr_q.size() !== 0 || done_cnt - done_base !== 1) begin
      failures++;
      $display("FAIL zero_quiet got=req%0d done%0d exp=req0 done1", req_addr_q.size(), done_cnt - done_base);
    end
    out_ready = 1'b0;
    start_run(32'h0000_9000, 30);
    repeat (5) tick();
    ctl_addr = 32'h0000_A000;
    ctl_words = 16'd99;
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
    wait_done(100, 1000, "busy_start");
    check_run(32'h0000_9000, 30, "busy_start");
  endtask

  task automatic test_reset_mid_burst();
    int cyc = 0;
    bit bad = 1'b0;
    gap_pct = 0;
    out_ready = 1'b1;
    start_run(32'h0000_7000, 64);
    while ((req_addr_q.size() == 0 || burst_sent < 10) && cyc < 300) begin
      tick();
      cyc++;
    end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    cyc = 0;
    while (burst_left > 0 && cyc < 200) begin
      tick();
      if (out_valid || ctl_busy || mi_valid) bad = 1'b1;
      cyc++;
    end
    repeat (3) tick();
    checks++;
    if (bad || out_valid !== 1'b0 || done_cnt !== done_base) begin
      failures++;
      $display("FAIL reset_mid_burst got=activity%0d ov%b done%0d exp=activity0 ov0 done0",
               bad, out_valid, done_cnt - done_base);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int sizes[6] = '{1, 64, 65, 128, 129, 0};
    for (int r = 0; r < 6; r++) begin
      logic [31:0] base;
      int words;
      int pct;
      base = (r == 0) ? 32'hFFFF_FFD0 : $urandom;
      words = (sizes[r] == 0) ? int'($urandom_range(1, 300)) : sizes[r];
      gap_pct = int'($urandom_range(0, 50));
      pct = int'($urandom_range(20, 100));
      start_run(base, words);
      wait_done(pct, 20000, "random");
      check_run(base, words, "random");
    end
    gap_pct = 0;
  endtask

  initial begin
    rst = 1'b1;
    ctl_start = 1'b0;
    ctl_abort = 1'b0;
    ctl_addr = '0;
    ctl_words = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold_ready();
    test_backpressure();
    test_abort();
    test_stall();
    test_zero_and_busy();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
